// File: rtl/mutative_port_arbiter_pkg.sv
// ============================================================================
// mutative_types : shared state encoding and port count for the port arbiter
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package mutative_types;

  localparam int ARB_PORTS = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/mutative_rr_picker.sv
// ============================================================================
// mutative_rr_picker : two-input round-robin picker (favours port != last_grant)
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module mutative_rr_picker
  import mutative_types::*;
(
  input  logic [ARB_PORTS-1:0] pending,
  input  logic                 last_grant,
  output logic                 grant_valid,
  output logic                 grant_idx
);

  always_comb begin
    grant_valid = |pending;
    // A lone requester wins outright; a tie goes to the port not served last.
    grant_idx   = (&pending) ? ~last_grant : pending[1];
  end

endmodule

`default_nettype wire

// File: rtl/mutative_port_arbiter.sv
// ============================================================================
// mutative_port_arbiter : 2-port round-robin front end for the mutative cache
// Optional grant statistics enabled by macro MUTATIVE_ARB_STATS_EN.
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module mutative_port_arbiter
  import mutative_types::*;
#(
  parameter int RST_PRIO = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ARB_PORTS-1:0][31:0]     req_addr,
  input  logic [ARB_PORTS-1:0][3:0]      req_rmask,
  input  logic [ARB_PORTS-1:0][3:0]      req_wmask,
  input  logic [ARB_PORTS-1:0][31:0]     req_wdata,
  output logic [ARB_PORTS-1:0][31:0]     req_rdata,
  output logic [ARB_PORTS-1:0]           req_resp,
  output logic [31:0]                    ufp_addr,
  output logic [3:0]                     ufp_rmask,
  output logic [3:0]                     ufp_wmask,
  output logic [31:0]                    ufp_wdata,
  input  logic [31:0]                    ufp_rdata,
  input  logic                           ufp_resp,
  output logic                           busy,
  output logic [ARB_PORTS-1:0][31:0]     grant_cnt
);

  localparam logic c_rst_last = (RST_PRIO == 0) ? 1'b1 : 1'b0;

  arb_state_t state_q, state_d;
  logic       last_q, last_d;
  logic       gnt_q, gnt_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  rmask_q, rmask_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [31:0] wdata_q, wdata_d;

  logic [ARB_PORTS-1:0] w_pending;
  logic                 w_pick_valid;
  logic                 w_pick_idx;
  logic                 w_grant;

  always_comb begin
    for (int i = 0; i < ARB_PORTS; i++) begin
      w_pending[i] = (|req_rmask[i]) | (|req_wmask[i]);
    end
  end

  mutative_rr_picker u_picker (
    .pending     (w_pending),
    .last_grant  (last_q),
    .grant_valid (w_pick_valid),
    .grant_idx   (w_pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= c_rst_last;
      gnt_q   <= 1'b0;
      addr_q  <= '0;
      rmask_q <= '0;
      wmask_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      rmask_q <= rmask_d;
      wmask_q <= wmask_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    addr_d    = addr_q;
    rmask_d   = rmask_q;
    wmask_d   = wmask_q;
    wdata_d   = wdata_q;
    w_grant   = 1'b0;
    ufp_addr  = addr_q;
    ufp_wdata = wdata_q;
    ufp_rmask = '0;
    ufp_wmask = '0;
    req_resp  = '0;
    req_rdata = '0;

    case (state_q)
      IDLE: begin
        if (w_pick_valid) begin
          w_grant = 1'b1;
          gnt_d   = w_pick_idx;
          last_d  = w_pick_idx;
          addr_d  = req_addr[w_pick_idx];
          rmask_d = req_rmask[w_pick_idx];
          wmask_d = req_wmask[w_pick_idx];
          wdata_d = req_wdata[w_pick_idx];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Masks live for this single cycle only; the cache would re-issue otherwise.
        ufp_rmask        = rmask_q;
        ufp_wmask        = wmask_q;
        req_resp[gnt_q]  = ufp_resp;
        req_rdata[gnt_q] = ufp_rdata;
        state_d          = ufp_resp ? IDLE : WAIT;
      end
      WAIT: begin
        req_resp[gnt_q]  = ufp_resp;
        req_rdata[gnt_q] = ufp_rdata;
        if (ufp_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

`ifdef MUTATIVE_ARB_STATS_EN
  for (genvar i = 0; i < ARB_PORTS; i++) begin : g_stat
    logic [31:0] cnt_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
      end else if (w_grant && (gnt_d == 1'(i)) && (cnt_q != 32'hFFFF_FFFF)) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
    assign grant_cnt[i] = cnt_q;
  end
`else
  assign grant_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mutative_port_arbiter.sv
// ============================================================================
// tb_mutative_port_arbiter : directed + randomized checks against a port model
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mutative_port_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0][31:0] req_addr;
  logic [1:0][3:0]  req_rmask;
  logic [1:0][3:0]  req_wmask;
  logic [1:0][31:0] req_wdata;
  logic [1:0][31:0] req_rdata;
  logic [1:0]       req_resp;
  logic [31:0]      ufp_addr;
  logic [3:0]       ufp_rmask;
  logic [3:0]       ufp_wmask;
  logic [31:0]      ufp_wdata;
  logic [31:0]      ufp_rdata;
  logic             ufp_resp;
  logic             busy;
  logic [1:0][31:0] grant_cnt;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: which ports hold a request, who was served last,
  // and how many grants each port has received.
  bit have [2];
  int last_g;
  int gcnt [2];

  always #5 clk = ~clk;

  mutative_port_arbiter #(.RST_PRIO(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_addr  (req_addr),
    .req_rmask (req_rmask),
    .req_wmask (req_wmask),
    .req_wdata (req_wdata),
    .req_rdata (req_rdata),
    .req_resp  (req_resp),
    .ufp_addr  (ufp_addr),
    .ufp_rmask (ufp_rmask),
    .ufp_wmask (ufp_wmask),
    .ufp_wdata (ufp_wdata),
    .ufp_rdata (ufp_rdata),
    .ufp_resp  (ufp_resp),
    .busy      (busy),
    .grant_cnt (grant_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input bit en);
    if (en) begin
      req_addr[i]  = $urandom;
      req_wdata[i] = $urandom;
      req_rmask[i] = 4'($urandom);
      req_wmask[i] = 4'($urandom);
      if (req_rmask[i] == 4'h0 && req_wmask[i] == 4'h0) req_rmask[i] = 4'hF;
    end else begin
      req_addr[i]  = '0;
      req_wdata[i] = '0;
      req_rmask[i] = '0;
      req_wmask[i] = '0;
    end
    have[i] = en;
  endtask

  task automatic check_stats(input string tag);
`ifdef MUTATIVE_ARB_STATS_EN
    check({tag, "_cnt0"}, grant_cnt[0], 32'(gcnt[0]));
    check({tag, "_cnt1"}, grant_cnt[1], 32'(gcnt[1]));
`else
    check({tag, "_cnt0"}, grant_cnt[0], 32'd0);
    check({tag, "_cnt1"}, grant_cnt[1], 32'd0);
`endif
  endtask

  // One full transaction. Called in an idle cycle after requests are set;
  // the cache answers lat cycles after the issue cycle (0 = same cycle).
  task automatic do_txn(input int lat, input logic [31:0] rd, output int p);
    bit seen;
    logic [31:0] e_addr;
    logic [1:0]  e_resp;
    if (have[0] && have[1]) p = 1 - last_g;
    else                    p = have[1] ? 1 : 0;
    e_addr = req_addr[p];
    e_resp = 2'b01 << p;
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      @(negedge clk); #1;
      if ((ufp_rmask | ufp_wmask) != 4'h0) seen = 1'b1;
    end
    check("issue_seen", 32'(seen), 32'd1);
    if (!seen) return;
    check("ufp_addr",  ufp_addr,        e_addr);
    check("ufp_rmask", 32'(ufp_rmask),  32'(req_rmask[p]));
    check("ufp_wmask", 32'(ufp_wmask),  32'(req_wmask[p]));
    check("ufp_wdata", ufp_wdata,       req_wdata[p]);
    check("busy_issue", 32'(busy),      32'd1);
    last_g = p;
    gcnt[p]++;
    if (lat == 0) begin
      ufp_resp = 1'b1; ufp_rdata = rd; #1;
    end else begin
      check("resp_early", 32'(req_resp), 32'd0);
      for (int k = 1; k <= lat; k++) begin
        @(negedge clk); #1;
        check("wait_masks", 32'({ufp_rmask, ufp_wmask}), 32'd0);
        check("wait_addr", ufp_addr, e_addr);
        check("busy_wait", 32'(busy), 32'd1);
        if (k == lat) begin
          ufp_resp = 1'b1; ufp_rdata = rd; #1;
        end else begin
          check("wait_resp", 32'(req_resp), 32'd0);
        end
      end
    end
    check("req_resp",   32'(req_resp),   32'(e_resp));
    check("rdata_gnt",  req_rdata[p],    rd);
    check("rdata_other", req_rdata[1-p], 32'd0);
    @(negedge clk);
    ufp_resp = 1'b0; ufp_rdata = $urandom; #1;
    check("busy_done", 32'(busy), 32'd0);
    check("resp_done", 32'(req_resp), 32'd0);
  endtask

  initial begin
    int p;
    int prev;
    rst = 1'b1;
    ufp_resp = 1'b0;
    ufp_rdata = '0;
    set_req(0, 1'b0);
    set_req(1, 1'b0);
    last_g = 1;
    gcnt[0] = 0; gcnt[1] = 0;
    #1;
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_ufp",   ufp_addr | ufp_wdata | 32'({ufp_rmask, ufp_wmask}), 32'd0);
    check("rst_resp",  32'(req_resp), 32'd0);
    check_stats("rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Instruction-port read with a 3-cycle cache latency.
    req_addr[0] = 32'h0000_1000; req_rmask[0] = 4'hF; have[0] = 1'b1;
    do_txn(3, 32'hDEAD_BEEF, p);
    check("rd_port", 32'(p), 32'd0);
    set_req(0, 1'b0);

    // Both ports saturated: grants must alternate.
    set_req(0, 1'b1); set_req(1, 1'b1);
    prev = last_g;
    for (int t = 0; t < 6; t++) begin
      do_txn(2, $urandom, p);
      check("alt_norepeat", 32'(p != prev), 32'd1);
      prev = p;
      set_req(p, 1'b1);
    end
    set_req(0, 1'b0); set_req(1, 1'b0);

    // Data-port write answered in the issue cycle.
    req_addr[1] = 32'h0000_2004; req_wmask[1] = 4'h3; req_wdata[1] = 32'h1234_5678;
    have[1] = 1'b1;
    do_txn(0, 32'h0, p);
    set_req(1, 1'b0);

    // Stray cache response while idle.
    @(negedge clk); ufp_resp = 1'b1; #1;
    check("spur_resp", 32'(req_resp), 32'd0);
    @(negedge clk); ufp_resp = 1'b0; #1;
    check("spur_busy", 32'(busy), 32'd0);

    for (int t = 0; t < 24; t++) begin
      if (!have[0] && !have[1]) set_req($urandom_range(0, 1), 1'b1);
      do_txn($urandom_range(0, 3), $urandom, p);
      set_req(p, $urandom_range(0, 3) != 0);
      if (!have[1-p]) set_req(1 - p, 1'(($urandom_range(0, 1))));
    end
    set_req(0, 1'b0); set_req(1, 1'b0);
    @(negedge clk);
    check_stats("stats");

    // Reset in the middle of a waiting transaction.
    set_req(0, 1'b1);
    @(negedge clk); #1;
    check("mid_issue", 32'(busy), 32'd1);
    @(negedge clk); #1;
    check("mid_wait", 32'(busy), 32'd1);
    #2 rst = 1'b1; #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ufp",  ufp_addr | ufp_wdata | 32'({ufp_rmask, ufp_wmask}), 32'd0);
    set_req(0, 1'b0);
    last_g = 1; gcnt[0] = 0; gcnt[1] = 0;
    @(negedge clk); rst = 1'b0; ufp_resp = 1'b1; #1;
    check("arst_resp", 32'(req_resp), 32'd0);
    @(negedge clk); ufp_resp = 1'b0; #1;
    check("arst_idle", 32'(busy), 32'd0);
    check_stats("arst");

    // After reset, a tie must go to the reset-priority port.
    set_req(0, 1'b1); set_req(1, 1'b1);
    do_txn(1, $urandom, p);
    set_req(p, 1'b0);
    do_txn(0, $urandom, p);
    set_req(p, 1'b0);
    @(negedge clk);
    check_stats("final");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/mutative_port_arbiter.md
MUTATIVE_PORT_ARBITER -- requirements
Module: mutative_port_arbiter

Interface
REQ-001 Parameter RST_PRIO, default 0, index of the port holding priority after reset.
REQ-002 Port clk  in  1  sole clock, rising edge.
REQ-003 Port rst  in  1  reset, asynchronous, active-high.
REQ-004 Port req_addr  in  2x32  per-port byte address (index 0 = instruction fetch, 1 = data).
REQ-005 Port req_rmask  in  2x4  per-port read byte mask; nonzero = read request.
REQ-006 Port req_wmask  in  2x4  per-port write byte mask; nonzero = write request.
REQ-007 Port req_wdata  in  2x32  per-port write data.
REQ-008 Port req_rdata  out  2x32  per-port read data.
REQ-009 Port req_resp  out  2  per-port one-cycle completion pulse.
REQ-010 Port ufp_addr / ufp_rmask / ufp_wmask / ufp_wdata  out  32/4/4/32  request to mutative_cache upward port.
REQ-011 Port ufp_rdata  in  32  cache read data; ufp_resp  in  1  cache completion.
REQ-012 Port busy  out  1  transaction outstanding (state != IDLE).
REQ-013 Port grant_cnt  out  2x32  per-port grant counters (see Configuration).

Function
REQ-014 Port pending = |req_rmask[i] or |req_wmask[i]; requester SHALL hold its request stable until its req_resp.
REQ-015 FSM states IDLE, ISSUE, WAIT; state register SHALL be sole sequential control.
REQ-016 IDLE: if any port pending, grant per round-robin (priority to port != last_grant; single pending port granted directly), latch addr/masks/wdata into hold register, go ISSUE.
REQ-017 ISSUE: drive held request on ufp_* for exactly one cycle; if ufp_resp same cycle go IDLE, else WAIT.
REQ-018 WAIT: ufp_rmask/ufp_wmask SHALL be 0, ufp_addr/ufp_wdata hold latched values; on ufp_resp go IDLE.
REQ-019 ufp_rmask/ufp_wmask SHALL be nonzero only in ISSUE (cache samples in its idle cycle; held masks would re-issue).
REQ-020 req_resp[g] = ufp_resp while state in {ISSUE, WAIT}, g = granted port; other port's req_resp = 0; req_rdata[g] = ufp_rdata combinationally, non-granted req_rdata = 0.
REQ-021 ufp_resp in IDLE SHALL be ignored (no req_resp).
REQ-022 last_grant updates on grant; minimum spacing between grants is 2 cycles; grant latency from pending to ISSUE is 1 cycle.
REQ-023 Simultaneous pending on both ports: grant alternates, each port served within one other transaction (no starvation).
REQ-024 Port with both masks nonzero SHALL be forwarded unchanged (no arbitration of masks).

Reset
REQ-025 During/after rst: state IDLE, last_grant = 1-RST_PRIO, hold register 0, all ufp_* outputs 0, req_resp 0, busy 0, grant_cnt 0.
REQ-026 Reset mid-transaction SHALL drop it silently; no req_resp for it after reset release.

Configuration
REQ-027 Macro MUTATIVE_ARB_STATS_EN defined: grant_cnt[i] increments on each grant to port i, saturating at 0xFFFFFFFF.
REQ-028 Macro undefined: counters not instantiated, grant_cnt tied to 0; all other behaviour identical.

Structure
REQ-029 Shared package mutative_types SHALL hold arb_state_t enum (IDLE, ISSUE, WAIT) and ARB_PORTS = 2.
REQ-030 Sub-module mutative_rr_picker (2-input round-robin, inputs pending + last_grant, outputs grant_valid + grant_idx) SHALL be used; rest is flat.

Verification
REQ-031 Port0 read 0x0000_1000 rmask 0xF, cache resp after 3 cycles with 0xDEAD_BEEF -> ufp_rmask 0xF for one cycle only, req_resp[0] pulse, req_rdata[0] = 0xDEAD_BEEF, port1 silent.
REQ-032 Both ports pending every cycle, cache resp 2 cycles after ISSUE, 6 transactions -> grants 1,0,1,0,1,0 (RST_PRIO=0 after reset), no repeat grants.
REQ-033 Port1 write 0x0000_2004 wmask 0x3 wdata 0x1234_5678 with ufp_resp in ISSUE cycle -> req_resp[1] same cycle, IDLE next cycle, write fields exact on ufp.
REQ-034 rst asserted in WAIT, ufp_resp pulsed after release -> no req_resp, busy 0, ufp_* 0 asynchronously.
REQ-035 Spurious ufp_resp in IDLE -> req_resp stays 0.
REQ-036 With MUTATIVE_ARB_STATS_EN, 10 port0 + 7 port1 grants -> grant_cnt = {7,10}; without macro grant_cnt = 0.
